// File: rtl/alu_issue_arbiter_if.sv
// Request, response and ALU-side bundle of alu_issue_arbiter.
// slave is the arbiter's view; master is the view of the surrounding issue stage / consumer / ALU.
interface alu_issue_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [0:63] req0_rA;
    logic [0:63] req0_rB;
    logic [0:5]  req0_func;
    logic [0:1]  req0_ww;

    logic        req1_valid;
    logic        req1_ready;
    logic [0:63] req1_rA;
    logic [0:63] req1_rB;
    logic [0:5]  req1_func;
    logic [0:1]  req1_ww;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [0:63] resp_data;
    logic        resp_err;

    logic [0:63] alu_rA;
    logic [0:63] alu_rB;
    logic [0:5]  alu_R_ins;
    logic [0:5]  alu_Op_code;
    logic [0:1]  alu_WW;
    logic [0:63] alu_out;

    modport slave (
        input  req0_valid, req0_rA, req0_rB, req0_func, req0_ww,
        output req0_ready,
        input  req1_valid, req1_rA, req1_rB, req1_func, req1_ww,
        output req1_ready,
        output resp_valid, resp_id, resp_data, resp_err,
        input  resp_ready,
        output alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW,
        input  alu_out
    );

    modport master (
        output req0_valid, req0_rA, req0_rB, req0_func, req0_ww,
        input  req0_ready,
        output req1_valid, req1_rA, req1_rB, req1_func, req1_ww,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data, resp_err,
        output resp_ready,
        input  alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW,
        output alu_out
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of one shared combinational vector ALU (IDLE -> EXEC -> RESP).
// Optional macro ALU_ILLEGAL_TRAP_EN: illegal function codes bypass the ALU and answer with resp_err=1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1. reqX_ready is
// combinational and only asserted in IDLE for the arbitration winner; requesters hold valid and
// payload until ready. resp_valid/resp_id/resp_data/resp_err stay stable until resp_ready is seen.
module alu_issue_arbiter #(
    parameter int         LAT_SHORT  = 1,
    parameter int         LAT_LONG   = 4,
    parameter int         CNT_W      = 4,
    parameter logic [5:0] ALU_OPCODE = 6'b101010
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_issue_arbiter_if.slave  bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(LAT_SHORT - 1);
    localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(LAT_LONG - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rr_last;

    logic             resp_valid_q;
    logic             resp_id_q;
    logic [0:63]      resp_data_q;
    logic             resp_err_q;
    logic [0:63]      alu_ra_q;
    logic [0:63]      alu_rb_q;
    logic [0:5]       alu_func_q;
    logic [0:5]       alu_opcode_q;
    logic [0:1]       alu_ww_q;

    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [0:63]      win_ra;
    logic [0:63]      win_rb;
    logic [0:5]       win_func;
    logic [0:1]       win_ww;
    logic             win_long;
    logic             win_illegal;

    // On a tie the requester not granted last wins; rr_last resets to 1 so requester 0 wins first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = rr_last;
                grant1 = !rr_last;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign grant_any = grant0 || grant1;
    assign win_ra    = grant1 ? bus.req1_rA   : bus.req0_rA;
    assign win_rb    = grant1 ? bus.req1_rB   : bus.req0_rB;
    assign win_func  = grant1 ? bus.req1_func : bus.req0_func;
    assign win_ww    = grant1 ? bus.req1_ww   : bus.req0_ww;

    // Long class: VMULEU/VMULOU (001000/001001), VDIV/VMOD (001110/001111),
    // VSQEU/VSQOU/VSQRT (010000..010010). Every other code, legal or not, is short.
    assign win_long = (win_func == 6'b001000) || (win_func == 6'b001001) ||
                      ((win_func >= 6'b001110) && (win_func <= 6'b010010));

`ifdef ALU_ILLEGAL_TRAP_EN
    assign win_illegal = (win_func == 6'b000000) || (win_func > 6'b010010);
`else
    assign win_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_last      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            alu_ra_q     <= '0;
            alu_rb_q     <= '0;
            alu_func_q   <= '0;
            alu_opcode_q <= '0;
            alu_ww_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rr_last   <= grant1;
                        resp_id_q <= grant1;
                        if (win_illegal) begin
                            // Trapped ops never touch the ALU inputs.
                            resp_data_q  <= '0;
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else begin
                            alu_ra_q     <= win_ra;
                            alu_rb_q     <= win_rb;
                            alu_func_q   <= win_func;
                            alu_ww_q     <= win_ww;
                            alu_opcode_q <= ALU_OPCODE;
                            resp_err_q   <= 1'b0;
                            cnt          <= win_long ? CNT_LONG : CNT_SHORT;
                            state        <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        resp_data_q  <= bus.alu_out;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.alu_rA      = alu_ra_q;
    assign bus.alu_rB      = alu_rb_q;
    assign bus.alu_R_ins   = alu_func_q;
    assign bus.alu_Op_code = alu_opcode_q;
    assign bus.alu_WW      = alu_ww_q;
    assign dbg_state       = state;

endmodule
